// File: rtl/operand_gather_seq.sv
// Operand gather sequencer: steps the 4:1 operand mux over the masked slots in ascending
// order and packs the captured words into one wide result. Optional macro: GATHER_PARITY_EN.
module operand_gather_seq #(
   parameter int bus_size = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [3:0]            mask,
   output logic                  busy,
   output logic [1:0]            mux_sel,
   input  logic [bus_size-1:0]   mux_out,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*bus_size-1:0] out_data,
`ifdef GATHER_PARITY_EN
   output logic [3:0]            out_parity,
`endif
   output logic [3:0]            out_mask
);

   typedef enum logic [1:0] {IDLE, GATHER, DONE} state_t;

   state_t     state;
   logic [3:0] rem;
   logic [1:0] lsb;
   logic       load;

   always_comb begin
      lsb = 2'd0;
      if      (rem[0]) lsb = 2'd0;
      else if (rem[1]) lsb = 2'd1;
      else if (rem[2]) lsb = 2'd2;
      else if (rem[3]) lsb = 2'd3;
   end

   // A new request is taken in IDLE, or in DONE when the current result is consumed.
   assign load      = start && (state == IDLE || (state == DONE && out_ready));
   assign mux_sel   = (state == GATHER) ? lsb : 2'd0;
   assign busy      = (state != IDLE);
   assign out_valid = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         rem      <= 4'd0;
         out_data <= '0;
         out_mask <= 4'd0;
`ifdef GATHER_PARITY_EN
         out_parity <= 4'd0;
`endif
      end else if (load) begin
         rem      <= mask;
         out_mask <= mask;
         out_data <= '0;
`ifdef GATHER_PARITY_EN
         out_parity <= 4'd0;
`endif
         state    <= (mask != 4'd0) ? GATHER : DONE;
      end else begin
         case (state)
            GATHER: begin
               out_data[lsb*bus_size +: bus_size] <= mux_out;
`ifdef GATHER_PARITY_EN
               out_parity[lsb] <= ^mux_out;
`endif
               rem[lsb] <= 1'b0;
               if ((rem & ~(4'b0001 << lsb)) == 4'd0) state <= DONE;
            end
            DONE:    if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_operand_gather_seq.sv
// Self-checking bench for operand_gather_seq: directed scenarios plus randomized gathers
// compared against a slot-level reference model.
module tb_operand_gather_seq;

   localparam int BW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [3:0]    mask;
   logic          busy;
   logic [1:0]    mux_sel;
   logic [BW-1:0] mux_out;
   logic          out_valid;
   logic          out_ready;
   logic [4*BW-1:0] out_data;
   logic [3:0]    out_mask;
`ifdef GATHER_PARITY_EN
   logic [3:0]    out_parity;
`endif

   logic [BW-1:0] src [4];
   int vec = 0;
   int errs = 0;

   always #5 clk = ~clk;

   assign mux_out = src[mux_sel];

   operand_gather_seq #(.bus_size(BW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mask(mask), .busy(busy),
      .mux_sel(mux_sel), .mux_out(mux_out), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data),
`ifdef GATHER_PARITY_EN
      .out_parity(out_parity),
`endif
      .out_mask(out_mask)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [4*BW-1:0] model_data(input logic [3:0] m);
      logic [4*BW-1:0] d = '0;
      for (int i = 0; i < 4; i++) if (m[i]) d[i*BW +: BW] = src[i];
      return d;
   endfunction

   function automatic logic [3:0] model_par(input logic [3:0] m);
      logic [3:0] p = '0;
      for (int i = 0; i < 4; i++) if (m[i]) p[i] = ^src[i];
      return p;
   endfunction

   // Checks the gather walk after start has been sampled; leaves the DUT in DONE.
   task automatic walk(input string tag, input logic [3:0] m);
      for (int i = 0; i < 4; i++) begin
         if (m[i]) begin
            chk({tag, " sel"},   64'(mux_sel), 64'(i));
            chk({tag, " noval"}, 64'(out_valid), 64'd0);
            chk({tag, " busy"},  64'(busy), 64'd1);
            step();
         end
      end
      chk({tag, " valid"}, 64'(out_valid), 64'd1);
      chk({tag, " data"},  out_data, model_data(m));
      chk({tag, " mask"},  64'(out_mask), 64'(m));
      chk({tag, " dsel"},  64'(mux_sel), 64'd0);
`ifdef GATHER_PARITY_EN
      chk({tag, " par"},   64'(out_parity), 64'(model_par(m)));
`endif
   endtask

   task automatic gather(input string tag, input logic [3:0] m);
      mask = m; start = 1'b1;
      step();
      start = 1'b0; mask = $urandom;
      walk(tag, m);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({tag, " idle"}, 64'({busy, out_valid}), 64'd0);
   endtask

   initial begin
      logic [4*BW-1:0] held;
      rst_n = 1'b0; start = 1'b0; mask = 4'd0; out_ready = 1'b0;
      for (int i = 0; i < 4; i++) src[i] = '0;
      #12;
      chk("rst busy",  64'(busy), 64'd0);
      chk("rst valid", 64'(out_valid), 64'd0);
      chk("rst data",  out_data, 64'd0);
      chk("rst mask",  64'(out_mask), 64'd0);
      chk("rst sel",   64'(mux_sel), 64'd0);
      rst_n = 1'b1;
      step();

      src[0] = 16'h1111; src[1] = 16'h2222; src[2] = 16'h3333; src[3] = 16'h4444;
      gather("full", 4'b1111);
      chk("full const", model_data(4'b1111), 64'h4444_3333_2222_1111);
      gather("m1010", 4'b1010);
      gather("zero", 4'b0000);

      // Held result, ignored start, then back-to-back accept.
      mask = 4'b0110; start = 1'b1; step(); start = 1'b0;
      walk("hold", 4'b0110);
      held = out_data;
      for (int c = 0; c < 5; c++) begin
         start = (c == 2); mask = 4'b0001;
         step();
         chk("hold valid", 64'(out_valid), 64'd1);
         chk("hold data",  out_data, held);
         chk("hold mask",  64'(out_mask), 64'b0110);
      end
      start = 1'b1; out_ready = 1'b1; mask = 4'b0100;
      step();
      start = 1'b0; out_ready = 1'b0;
      chk("b2b valid", 64'(out_valid), 64'd0);
      chk("b2b sel",   64'(mux_sel), 64'd2);
      walk("b2b", 4'b0100);
      out_ready = 1'b1; step(); out_ready = 1'b0;

      // Reset mid-gather after two words.
      mask = 4'b1111; start = 1'b1; step(); start = 1'b0;
      step(); step();
      chk("mid busy", 64'(busy), 64'd1);
      rst_n = 1'b0; #1;
      chk("ab busy",  64'(busy), 64'd0);
      chk("ab valid", 64'(out_valid), 64'd0);
      chk("ab data",  out_data, 64'd0);
      chk("ab mask",  64'(out_mask), 64'd0);
      chk("ab sel",   64'(mux_sel), 64'd0);
      step();
      rst_n = 1'b1;
      step();
      chk("ab idle", 64'(out_valid), 64'd0);

      src[0] = 16'h0001; src[1] = 16'h0003;
      gather("par", 4'b0011);
`ifdef GATHER_PARITY_EN
      chk("par const", 64'(model_par(4'b0011)), 64'b0001);
`endif

      for (int n = 0; n < 30; n++) begin
         for (int i = 0; i < 4; i++) src[i] = BW'($urandom);
         gather("rnd", 4'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
